// File: rtl/ex_pkg.sv
// Shared constants, enums and helpers for the long-op execute sequencer.
package ex_pkg;

    localparam logic [9:0] CSEL_DIV = 10'b00_0000_1000;
    localparam logic [9:0] CSEL_MUL = 10'b00_1000_0000;

    localparam int unsigned PSW_CY = 3;
    localparam int unsigned PSW_OV = 2;
    localparam int unsigned PSW_S  = 1;
    localparam int unsigned PSW_Z  = 0;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2
    } op_class_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL1    = 3'd1,
        DIV_RUN = 3'd2,
        DIV_FIX = 3'd3,
        DONE    = 3'd4
    } state_e;

    function automatic op_class_e op_class(input logic [9:0] csel);
        op_class_e c;
        c = SINGLE;
        if (csel == CSEL_DIV) c = DIV;
        else if (csel == CSEL_MUL) c = MUL;
        return c;
    endfunction

    // DIV flag word: CY always 0 (never written), S/Z follow the quotient.
    function automatic logic [3:0] div_flags(input logic ov, input logic [31:0] quo);
        logic [3:0] f;
        f         = 4'b0000;
        f[PSW_OV] = ov;
        f[PSW_S]  = quo[31];
        f[PSW_Z]  = (quo == 32'd0);
        return f;
    endfunction

endpackage

// File: rtl/ex_longop_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider: one quotient bit per step.
module div_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Quotient register doubles as the dividend shift register.
    assign w_shift = {r_rem, r_quo[31]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (load) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dvs <= divisor;
        end else if (step) begin
            if (!w_diff[32]) begin
                r_rem <= w_diff[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_shift[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/ex_longop_ctrl.sv
// Long-op sequencer: forwards single-cycle ops, runs MUL/DIV internally and
// hands results to MEM through a valid/ready handshake.
module ex_longop_ctrl
    import ex_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CSEL_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CSEL_W-1:0] circuit_sel_i,
    input  logic [4:0]        destination_i,
    input  logic [4:0]        destination2_i,
    input  logic [31:0]       reg1_i,
    input  logic [31:0]       reg2_i,
    output logic              ex_issue_o,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       result_o,
    output logic [31:0]       result2_o,
    output logic [4:0]        destination_o,
    output logic [4:0]        destination2_o,
    output logic [3:0]        psw_flags_o,
    output logic [3:0]        psw_we_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_op1;
    logic [31:0]      r_op2;
    logic             r_dvd_neg;
    logic             r_dvs_neg;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_out_valid;
    logic [31:0]      r_result;
    logic [31:0]      r_result2;
    logic [4:0]       r_dest;
    logic [4:0]       r_dest2;
    logic [3:0]       r_flags;
    logic [3:0]       r_we;

    op_class_e   w_class;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_div_load;
    logic        w_div_step;
    logic [31:0] w_mag_dvd;
    logic [31:0] w_mag_dvs;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [63:0] w_prod;

    assign w_class    = op_class(10'(circuit_sel_i));
    assign w_div_zero = (reg1_i == 32'd0);
    assign w_div_ovf  = (reg2_i == 32'h8000_0000) && (reg1_i == 32'hFFFF_FFFF);
    assign w_mag_dvd  = reg2_i[31] ? -reg2_i : reg2_i;
    assign w_mag_dvs  = reg1_i[31] ? -reg1_i : reg1_i;

    assign w_div_load = (r_state == IDLE) && in_valid_i && !flush_i && (w_class == DIV)
                        && !w_div_zero && !w_div_ovf;
    assign w_div_step = (r_state == DIV_RUN) && !flush_i;

    assign ex_issue_o = (r_state == IDLE) && in_valid_i && !flush_i && (w_class == SINGLE);

    assign w_prod  = $signed({{32{r_op2[31]}}, r_op2}) * $signed({{32{r_op1[31]}}, r_op1});
    assign w_q_fix = (r_dvd_neg ^ r_dvs_neg) ? -w_quo : w_quo;
    assign w_r_fix = r_dvd_neg ? -w_rem : w_rem;

    div_iter u_div_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_div_load),
        .step      (w_div_step),
        .dividend  (w_mag_dvd),
        .divisor   (w_mag_dvs),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_dvd_neg   <= 1'b0;
            r_dvs_neg   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result2   <= '0;
            r_dest      <= '0;
            r_dest2     <= '0;
            r_flags     <= '0;
            r_we        <= '0;
        end else if (flush_i) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i && (w_class != SINGLE)) begin
                        r_dest     <= destination_i;
                        r_dest2    <= destination2_i;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_class == MUL) begin
                            r_op1   <= reg1_i;
                            r_op2   <= reg2_i;
                            r_state <= MUL1;
                        end else begin
                            r_we <= 4'b0111;
                            // Zero divisor and INT_MIN/-1 skip the iteration.
                            if (w_div_zero) begin
                                r_result    <= 32'd0;
                                r_result2   <= reg2_i;
                                r_flags     <= div_flags(1'b1, 32'd0);
                                r_out_valid <= 1'b1;
                                r_state     <= DONE;
                            end else if (w_div_ovf) begin
                                r_result    <= 32'h8000_0000;
                                r_result2   <= 32'd0;
                                r_flags     <= div_flags(1'b1, 32'h8000_0000);
                                r_out_valid <= 1'b1;
                                r_state     <= DONE;
                            end else begin
                                r_dvd_neg <= reg2_i[31];
                                r_dvs_neg <= reg1_i[31];
                                r_cnt     <= CNT_W'(DIV_CYCLES);
                                r_state   <= DIV_RUN;
                            end
                        end
                    end
                end
                MUL1: begin
                    r_result    <= w_prod[31:0];
                    r_result2   <= w_prod[63:32];
                    r_flags     <= 4'b0000;
                    r_we        <= 4'b0000;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DIV_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= DIV_FIX;
                end
                DIV_FIX: begin
                    r_result    <= w_q_fix;
                    r_result2   <= w_r_fix;
                    r_flags     <= div_flags(1'b0, w_q_fix);
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready_o     = r_in_ready;
    assign busy_o         = r_busy;
    assign out_valid_o    = r_out_valid;
    assign result_o       = r_result;
    assign result2_o      = r_result2;
    assign destination_o  = r_dest;
    assign destination2_o = r_dest2;
    assign psw_flags_o    = r_flags;
    assign psw_we_o       = r_we;

endmodule

// File: tb/tb_ex_longop_ctrl.sv
// Scoreboard bench for ex_longop_ctrl: stimulus pushes expected results,
// a negedge monitor checks them whenever out_valid_o is high.
module tb_ex_longop_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [9:0]  circuit_sel_i;
    logic [4:0]  destination_i;
    logic [4:0]  destination2_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic        ex_issue_o;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] result_o;
    logic [31:0] result2_o;
    logic [4:0]  destination_o;
    logic [4:0]  destination2_o;
    logic [3:0]  psw_flags_o;
    logic [3:0]  psw_we_o;
    logic        busy_o;

    localparam logic [9:0] C_ADD = 10'b00_0010_0000;
    localparam logic [9:0] C_DIV = 10'b00_0000_1000;
    localparam logic [9:0] C_MUL = 10'b00_1000_0000;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] res2;
        logic [4:0]  d;
        logic [4:0]  d2;
        logic [3:0]  fl;
        logic [3:0]  we;
        int          first_cyc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    logic prev_valid = 1'b0;

    ex_longop_ctrl #(.DIV_CYCLES(32), .CSEL_W(10)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .circuit_sel_i  (circuit_sel_i),
        .destination_i  (destination_i),
        .destination2_i (destination2_i),
        .reg1_i         (reg1_i),
        .reg2_i         (reg2_i),
        .ex_issue_o     (ex_issue_o),
        .flush_i        (flush_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .result_o       (result_o),
        .result2_o      (result2_o),
        .destination_o  (destination_o),
        .destination2_o (destination2_o),
        .psw_flags_o    (psw_flags_o),
        .psw_we_o       (psw_we_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every valid cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid_o) begin
            if (q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_valid: out_valid_o=1 with no op outstanding (cycle %0d)", cyc);
            end else begin
                if (!prev_valid) chk({q[0].name, "_latency"}, 64'(cyc), 64'(q[0].first_cyc));
                chk({q[0].name, "_result"},   64'(result_o),       64'(q[0].res));
                chk({q[0].name, "_result2"},  64'(result2_o),      64'(q[0].res2));
                chk({q[0].name, "_dest"},     64'(destination_o),  64'(q[0].d));
                chk({q[0].name, "_dest2"},    64'(destination2_o), 64'(q[0].d2));
                chk({q[0].name, "_flags"},    64'(psw_flags_o),    64'(q[0].fl));
                chk({q[0].name, "_we"},       64'(psw_we_o),       64'(q[0].we));
                chk({q[0].name, "_in_ready"}, 64'(in_ready_o),     64'(0));
                if (out_ready_i) void'(q.pop_front());
            end
        end
        prev_valid = rst_n && out_valid_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_op(input string nm, input logic [31:0] r, input logic [31:0] r2,
                             input logic [4:0] d, input logic [4:0] d2, input logic [3:0] fl,
                             input logic [3:0] we, input int lat);
        exp_t e;
        e.name = nm; e.res = r; e.res2 = r2; e.d = d; e.d2 = d2;
        e.fl = fl; e.we = we; e.first_cyc = cyc + lat;
        q.push_back(e);
    endtask

    // Presents one op for a single cycle; returns in cycle 1 after the accept edge.
    task automatic issue(input logic [9:0] c, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] d, input logic [4:0] d2);
        in_valid_i = 1'b1; circuit_sel_i = c; reg1_i = r1; reg2_i = r2;
        destination_i = d; destination2_i = d2;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy_o || out_valid_o) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk({nm, "_timeout"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; in_valid_i = 1'b0; circuit_sel_i = '0; destination_i = '0;
        destination2_i = '0; reg1_i = '0; reg2_i = '0; flush_i = 1'b0; out_ready_i = 1'b1;
        step(); step();
        chk("rst_in_ready",  64'(in_ready_o),  64'(1));
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_busy",      64'(busy_o),      64'(0));
        chk("rst_ex_issue",  64'(ex_issue_o),  64'(0));
        chk("rst_results",   {result2_o, result_o}, 64'(0));
        chk("rst_psw",       64'({psw_flags_o, psw_we_o, destination_o, destination2_o}), 64'(0));
        rst_n = 1'b1;
        step();

        // Single-cycle op: combinational issue, no state change.
        in_valid_i = 1'b1; circuit_sel_i = C_ADD;
        #1;
        chk("add_issue", 64'(ex_issue_o), 64'(1));
        step();
        in_valid_i = 1'b0;
        chk("add_busy",  64'(busy_o),     64'(0));
        chk("add_ready", 64'(in_ready_o), 64'(1));

        // Flush in IDLE suppresses issue and acceptance.
        in_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("flush_idle_issue", 64'(ex_issue_o), 64'(0));
        circuit_sel_i = C_MUL;
        step();
        in_valid_i = 1'b0; flush_i = 1'b0;
        chk("flush_idle_busy", 64'(busy_o), 64'(0));

        // MUL -2 * 3 with in_ready low during cycles 1-2.
        expect_op("mul_neg", 32'hFFFF_FFFA, 32'hFFFF_FFFF, 5'd3, 5'd4, 4'b0000, 4'b0000, 2);
        issue(C_MUL, 32'd3, 32'hFFFF_FFFE, 5'd3, 5'd4);
        chk("mul_ready_c1", 64'(in_ready_o), 64'(0));
        chk("mul_busy_c1",  64'(busy_o),     64'(1));
        wait_idle("mul_neg");

        expect_op("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'd5, 5'd6, 4'b0010, 4'b0111, 34);
        issue(C_DIV, 32'd2, 32'hFFFF_FFF9, 5'd5, 5'd6);
        wait_idle("div_m7_2");

        expect_op("div_100_7", 32'd14, 32'd2, 5'd7, 5'd8, 4'b0000, 4'b0111, 34);
        issue(C_DIV, 32'd7, 32'd100, 5'd7, 5'd8);
        wait_idle("div_100_7");

        expect_op("div_7_m2", 32'hFFFF_FFFD, 32'd1, 5'd9, 5'd10, 4'b0010, 4'b0111, 34);
        issue(C_DIV, 32'hFFFF_FFFE, 32'd7, 5'd9, 5'd10);
        wait_idle("div_7_m2");

        expect_op("div_0_5", 32'd0, 32'd0, 5'd11, 5'd12, 4'b0001, 4'b0111, 34);
        issue(C_DIV, 32'd5, 32'd0, 5'd11, 5'd12);
        wait_idle("div_0_5");

        expect_op("div_by0", 32'd0, 32'd5, 5'd13, 5'd14, 4'b0101, 4'b0111, 1);
        issue(C_DIV, 32'd0, 32'd5, 5'd13, 5'd14);
        wait_idle("div_by0");

        expect_op("div_ovf", 32'h8000_0000, 32'd0, 5'd15, 5'd16, 4'b0110, 4'b0111, 1);
        issue(C_DIV, 32'hFFFF_FFFF, 32'h8000_0000, 5'd15, 5'd16);
        wait_idle("div_ovf");

        // r0 destination passes through untouched.
        expect_op("mul_r0", 32'd0, 32'd1, 5'd0, 5'd0, 4'b0000, 4'b0000, 2);
        issue(C_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, 5'd0);
        wait_idle("mul_r0");

        // Backpressure: hold DONE for 5 cycles with a competing op offered.
        out_ready_i = 1'b0;
        expect_op("mul_bp", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 5'd17, 5'd18, 4'b0000, 4'b0000, 2);
        issue(C_MUL, 32'hFFFF_FFFF, 32'd5, 5'd17, 5'd18);
        for (int i = 0; i < 10 && !out_valid_o; i++) step();
        chk("bp_valid_seen", 64'(out_valid_o), 64'(1));
        in_valid_i = 1'b1; circuit_sel_i = C_MUL;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", 64'(in_ready_o),  64'(0));
            chk("bp_valid",    64'(out_valid_o), 64'(1));
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk("bp_release_valid", 64'(out_valid_o), 64'(0));
        chk("bp_release_ready", 64'(in_ready_o),  64'(1));
        chk("bp_release_busy",  64'(busy_o),      64'(0));

        // Flush at cycle 10 of a DIV.
        issue(C_DIV, 32'd3, 32'd1000, 5'd19, 5'd20);
        repeat (8) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_div_busy",  64'(busy_o),      64'(0));
        chk("flush_div_ready", 64'(in_ready_o),  64'(1));
        chk("flush_div_valid", 64'(out_valid_o), 64'(0));
        expect_op("mul_after_flush", 32'd42, 32'd0, 5'd21, 5'd22, 4'b0000, 4'b0000, 2);
        issue(C_MUL, 32'd6, 32'd7, 5'd21, 5'd22);
        wait_idle("mul_after_flush");

        // Asynchronous reset mid-DIV.
        issue(C_DIV, 32'd3, 32'd1000, 5'd23, 5'd24);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",   64'(busy_o),      64'(0));
        chk("rst_mid_ready",  64'(in_ready_o),  64'(1));
        chk("rst_mid_valid",  64'(out_valid_o), 64'(0));
        chk("rst_mid_dest",   64'({destination_o, destination2_o}), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        expect_op("mul_after_rst", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 5'd25, 5'd26, 4'b0000, 4'b0000, 2);
        issue(C_MUL, 32'hFFFF_FFFF, 32'd7, 5'd25, 5'd26);
        wait_idle("mul_after_rst");

        step();
        chk("scoreboard_empty", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_longop_ctrl.md
# ex_longop_ctrl

Sequencer for multi-cycle execute-stage operations (DIV, MUL/MULH) in the V850 pipeline, sitting between the decoder and the single-cycle Executer. It classifies each issued op by its `circuit_sel` code. Single-cycle ops are forwarded to the Executer. Long ops are captured and run internally while the decoder is stalled, and their results and flag updates are presented to the MEM stage through a valid/ready handshake.

## Interface
Parameters:
- `DIV_CYCLES`, 32, number of radix-2 divide iterations (one per quotient bit).
- `CSEL_W`, 10, width of `circuit_sel`.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid_i` in 1: decoder presents an op.
- `in_ready_o` out 1: block accepts an op this cycle.
- `circuit_sel_i` in CSEL_W: op select.
- `destination_i`, `destination2_i` in 5: destination register numbers.
- `reg1_i`, `reg2_i` in 32: operands. For DIV, reg2 is the dividend and reg1 is the divisor.
- `ex_issue_o` out 1: forward a single-cycle op to the Executer (combinational).
- `flush_i` in 1: abort any op in flight.
- `out_valid_o` out 1: long-op result valid.
- `out_ready_i` in 1: MEM stage accepts the result.
- `result_o`, `result2_o` out 32: result values.
  - MUL: low and high product words.
  - DIV: quotient and remainder.
- `destination_o`, `destination2_o` out 5: register numbers for `result_o` and `result2_o`.
- `psw_flags_o` out 4: flags {CY, OV, S, Z}.
- `psw_we_o` out 4: per-flag write enables.
- `busy_o` out 1: a long op is in flight (state is not IDLE).

## Operation
Op classes, decoded from `circuit_sel_i`:
- CSEL_DIV (10'b00_0000_1000) is a DIV.
- CSEL_MUL (10'b00_1000_0000) is a MUL.
- Every other code is SINGLE.

States:
- IDLE
  - `in_ready_o`=1.
  - `ex_issue_o` = `in_valid_i` & class==SINGLE. The block stays in IDLE.
  - On `in_valid_i` with MUL: capture operands and destinations, go to MUL1.
  - On `in_valid_i` with DIV:
    - divisor==0: go to DONE with quotient=0, remainder=dividend, OV=1.
    - dividend==32'h8000_0000 and divisor==32'hFFFF_FFFF: go to DONE with quotient=32'h8000_0000, remainder=0, OV=1.
    - otherwise: load `div_iter` with the operand magnitudes, go to DIV_RUN.
- MUL1
  - Register the signed 64-bit product into {`result2_o`, `result_o`}.
  - `psw_we_o`=4'b0000: MUL does not change flags.
  - Go to DONE.
- DIV_RUN
  - One `div_iter` step per cycle for DIV_CYCLES cycles, counted by a down-counter.
  - Go to DIV_FIX when the count reaches 0.
- DIV_FIX
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Flags: OV=0, S=quotient[31], Z=(quotient==0).
  - Go to DONE.
- DONE
  - `out_valid_o`=1. Outputs are held stable until `out_ready_i`, then go to IDLE.
  - DIV: `psw_we_o`=4'b0111, CY is never written.

Boundary rules:
- `in_ready_o`=0 in every state other than IDLE. No op is accepted while DONE is held.
- `flush_i` takes priority in any state: next state is IDLE, and `out_valid_o` is deasserted next cycle. A flush in IDLE suppresses `ex_issue_o` in that same cycle.
- `rst_n` low mid-operation: immediate return to IDLE, all outputs at reset values.
- `destination_o` = r0 is passed through unmodified; write suppression belongs to writeback.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready_o`=1, `ex_issue_o`=0, `out_valid_o`=0, `busy_o`=0.
  - `result_o`, `result2_o`=0; `destination_o`, `destination2_o`=0; `psw_flags_o`=0; `psw_we_o`=0.
- Latency, with the accept edge as cycle 0:
  - MUL: `out_valid_o` in cycle 2.
  - Normal DIV: `out_valid_o` in cycle DIV_CYCLES+2 (34 by default).
  - DIV fast paths (zero divisor, overflow): `out_valid_o` in cycle 1.
- `ex_issue_o` has zero latency (combinational) and is valid only in IDLE.
- Earliest next accept is the cycle after the `out_valid_o` & `out_ready_i` handshake.

## Structure
- Package `ex_pkg`, holding:
  - CSEL_DIV and CSEL_MUL constants.
  - Op-class enum {SINGLE, MUL, DIV}.
  - State enum {IDLE, MUL1, DIV_RUN, DIV_FIX, DONE}.
  - PSW bit indices CY=3, OV=2, S=1, Z=0.
- Sub-module `div_iter`: unsigned radix-2 restoring divider step.
  - Holds partial remainder and quotient registers.
  - Ports: load, step, dividend, divisor, quotient, remainder.
- The FSM, counter, sign fix-up and multiplier stay in `ex_longop_ctrl`.

## Test plan
- ADD op (10'b00_0010_0000) with `in_valid_i`=1 in IDLE -> `ex_issue_o`=1 in the same cycle, state stays IDLE, `busy_o`=0.
- MUL with reg2=32'hFFFF_FFFE, reg1=3 -> cycle 2 gives result2=32'hFFFF_FFFF, result=32'hFFFF_FFFA, `psw_we_o`=0, `in_ready_o`=0 during cycles 1-2.
- DIV with reg2=-7, reg1=2 -> cycle 34 gives quotient=32'hFFFF_FFFD, remainder=32'hFFFF_FFFF, flags OV=0 S=1 Z=0, `psw_we_o`=4'b0111.
- DIV with reg1=0 and reg2=5 -> cycle 1 gives quotient=0, remainder=5, OV=1. Separately, 32'h8000_0000 / 32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0, OV=1.
- Backpressure: `out_ready_i`=0 for 5 cycles in DONE -> outputs stay stable and `in_ready_o`=0; raise `out_ready_i` -> IDLE next cycle.
- `flush_i` at cycle 10 of a DIV, and separately `rst_n` pulsed low mid-DIV -> IDLE next cycle, `out_valid_o` never asserted, the next MUL completes correctly.
